// File: rtl/wca_port_scheduler.sv
// Round-robin owner of a shared port interface: latches one requester's command,
// settles the address, issues the command, then waits for idle or watchdog expiry.
module wca_port_scheduler #(
  parameter int COUNT_PORTS   = 4,
  parameter int NBITS_ADDR    = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [2*COUNT_PORTS-1:0] reqCmd,
  input  logic                     pifBusy,
  output logic [NBITS_ADDR+1:0]    pifCtrl,
  output logic [COUNT_PORTS-1:0]   grant,
  output logic [COUNT_PORTS-1:0]   done,
  output logic                     timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CMD,
    S_CMD_WAIT1,
    S_CMD_WAIT2,
    S_WAIT_COMPLETE
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             settle_q, settle_d;
  logic [7:0]             wdog_q, wdog_d;
  logic [NBITS_ADDR-1:0]  last_q, last_d;
  logic [NBITS_ADDR-1:0]  addr_q, addr_d;
  logic [1:0]             latch_q, latch_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [COUNT_PORTS-1:0] grant_q, grant_d;
  logic [COUNT_PORTS-1:0] done_q, done_d;
  logic                   timeout_q, timeout_d;

  logic [COUNT_PORTS-1:0] req_vld;
  logic [NBITS_ADDR-1:0]  win_idx;
  logic                   win_vld;
  logic                   arb_go;
  logic                   wc_done;
  logic                   wc_expire;

  always_comb begin
    for (int i = 0; i < COUNT_PORTS; i++) req_vld[i] = |reqCmd[2*i +: 2];
  end

  // First nonzero requester after the previous winner, wrapping modulo COUNT_PORTS.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= COUNT_PORTS; k++) begin
      idx = int'(last_q) + k;
      if (idx >= COUNT_PORTS) idx = idx - COUNT_PORTS;
      if (!win_vld && req_vld[idx]) begin
        win_vld = 1'b1;
        win_idx = NBITS_ADDR'(idx);
      end
    end
  end

  // The cycle carrying a done/timeout pulse is a dead IDLE cycle; arbitration resumes after it.
  assign arb_go    = (state_q == S_IDLE) && enable && win_vld && !(|done_q) && !timeout_q;
  assign wc_done   = (state_q == S_WAIT_COMPLETE) && !pifBusy;
  assign wc_expire = (state_q == S_WAIT_COMPLETE) && pifBusy && (TIMEOUT != 0) &&
                     (wdog_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      wdog_q    <= '0;
      last_q    <= NBITS_ADDR'(COUNT_PORTS - 1);
      addr_q    <= NBITS_ADDR'(COUNT_PORTS - 1);
      latch_q   <= 2'b00;
      cmd_q     <= 2'b00;
      grant_q   <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      wdog_q    <= wdog_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      latch_q   <= latch_d;
      cmd_q     <= cmd_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    wdog_d   = wdog_q;
    last_d   = last_q;
    latch_d  = latch_q;
    case (state_q)
      S_IDLE: begin
        if (arb_go) begin
          last_d   = win_idx;
          latch_d  = reqCmd[2*win_idx +: 2];
          settle_d = 4'(SETTLE_CYCLES);
          state_d  = (win_idx == addr_q) ? S_CMD : S_SETTLE;
        end
      end
      S_SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) state_d = S_CMD;
      end
      S_CMD:       state_d = S_CMD_WAIT1;
      S_CMD_WAIT1: state_d = S_CMD_WAIT2;
      S_CMD_WAIT2: state_d = S_WAIT_COMPLETE;
      S_WAIT_COMPLETE: begin
        if (wc_done || wc_expire) state_d = S_IDLE;
        else if (TIMEOUT != 0)    wdog_d  = wdog_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_CMD && state_q != S_CMD) wdog_d = '0;
  end

  always_comb begin
    addr_d    = addr_q;
    grant_d   = grant_q;
    done_d    = '0;
    timeout_d = 1'b0;
    cmd_d     = 2'b00;
    if (state_q inside {S_CMD, S_CMD_WAIT1, S_CMD_WAIT2}) cmd_d = latch_q;
    if (arb_go) begin
      addr_d           = win_idx;
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
    end
    if (wc_done) begin
      done_d  = grant_q;
      grant_d = '0;
    end
    if (wc_expire) begin
      timeout_d = 1'b1;
      grant_d   = '0;
    end
  end

  assign pifCtrl = {addr_q, cmd_q};
  assign grant   = grant_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_wca_port_scheduler.sv
// Bench for wca_port_scheduler: directed scenarios plus random traffic, every cycle
// compared against a transaction-timeline model (cycles elapsed since the grant).
module tb_wca_port_scheduler;
  localparam int N  = 4;
  localparam int NA = 2;
  localparam int S  = 3;
  localparam int TO = 10;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b1;
  logic            pifBusy = 1'b0;
  logic [2*N-1:0]  reqCmd = '0;
  logic [NA+1:0]   pifCtrl;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            timeout;

  int checks = 0;
  int errors = 0;

  wca_port_scheduler #(
    .COUNT_PORTS(N), .NBITS_ADDR(NA), .SETTLE_CYCLES(S), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .reqCmd(reqCmd), .pifBusy(pifBusy),
    .pifCtrl(pifCtrl), .grant(grant), .done(done), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Reference timeline: m_t counts edges since the grant edge; m_off is the settle delay.
  bit         m_active, m_dead;
  int         m_t, m_off, m_busy_edges, m_last, m_addr;
  logic [1:0] m_cmd;
  logic [N-1:0] e_grant, e_done;
  logic       e_to;

  function void model_reset();
    m_active = 0; m_dead = 0; m_t = 0; m_off = 0; m_busy_edges = 0;
    m_last = N - 1; m_addr = N - 1; m_cmd = 2'b00;
    e_grant = '0; e_done = '0; e_to = 1'b0;
  endfunction

  function void model_step();
    int w;
    w = -1;
    e_done = '0;
    e_to = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    if (!m_active) begin
      if (m_dead) m_dead = 0;
      else if (enable && reqCmd != '0) begin
        for (int k = 1; k <= N; k++)
          if (w < 0 && reqCmd[2*((m_last + k) % N) +: 2] != 2'b00) w = (m_last + k) % N;
        m_off = (w == m_addr) ? 0 : S;
        m_addr = w; m_last = w; m_cmd = reqCmd[2*w +: 2];
        m_active = 1; m_t = 0; m_busy_edges = 0;
        e_grant = N'(1) << w;
      end
    end else begin
      m_t++;
      if (m_t >= m_off + 4) begin
        if (!pifBusy) begin
          e_done = e_grant; e_grant = '0; m_active = 0; m_dead = 1;
        end else begin
          m_busy_edges++;
          if (m_busy_edges == TO) begin
            e_to = 1'b1; e_grant = '0; m_active = 0; m_dead = 1;
          end
        end
      end
    end
  endfunction

  function logic [NA+1:0] exp_ctrl();
    logic [1:0] c;
    c = 2'b00;
    if (m_active && m_t >= m_off + 1 && m_t <= m_off + 3) c = m_cmd;
    return {NA'(m_addr), c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("grant", grant, e_grant);
    chk("done", done, e_done);
    chk("timeout", timeout, e_to);
    chk("pifCtrl", pifCtrl, exp_ctrl());
  endtask

  initial begin
    int first_cmd, ncmd, ndone, nto, tgrant, tto, regrant, ngrant, hit;
    int gcyc[$];
    int rcyc[$];
    logic [N-1:0] gval[$];
    logic [N-1:0] prevg;
    logic [1:0]   prevc;

    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_ctrl", pifCtrl, 4'b1100);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_timeout", timeout, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // single request with address change, busy for 6 cycles from CMD_WAIT1
    reqCmd = 8'b00_01_00_00;
    first_cmd = -1; ncmd = 0; ndone = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) begin
        chk("t1_grant", grant, 4'b0100);
        chk("t1_addr", pifCtrl[3:2], 2);
        reqCmd = '0;
      end
      if (pifCtrl[1:0] != 2'b00) begin
        ncmd++;
        if (first_cmd < 0) first_cmd = i;
        chk("t1_cmd", pifCtrl[1:0], 2'b01);
      end
      if (done != '0) begin
        ndone++;
        chk("t1_done", done, 4'b0100);
      end
      if (i == 4)  pifBusy = 1'b1;
      if (i == 10) pifBusy = 1'b0;
    end
    chk("t1_cmd_start", first_cmd, 4);
    chk("t1_cmd_len", ncmd, 3);
    chk("t1_done_cnt", ndone, 1);
    chk("t1_grant_clr", grant, 4'b0000);

    // round robin from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    reqCmd = 8'b10_10_10_10;
    prevg = grant;
    for (int i = 0; i < 45; i++) begin
      step();
      if (grant != '0 && prevg == '0) begin
        gval.push_back(grant);
        gcyc.push_back(i);
      end
      prevg = grant;
    end
    chk("t2_grants", gval.size() >= 5, 1);
    if (gval.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("t2_order", gval[k], N'(1) << (k % N));
      for (int k = 1; k < 5; k++) chk("t2_period", gcyc[k] - gcyc[k-1], 9);
    end

    // requester 3 alone, back to back
    reqCmd = 8'b01_00_00_00;
    prevc = pifCtrl[1:0];
    for (int i = 0; i < 40; i++) begin
      step();
      if (pifCtrl[1:0] != 2'b00 && prevc == 2'b00) begin
        rcyc.push_back(i);
        chk("t3_addr", pifCtrl[3:2], 3);
      end
      prevc = pifCtrl[1:0];
    end
    chk("t3_pulses", rcyc.size() >= 5, 1);
    if (rcyc.size() >= 5)
      for (int k = 2; k < 5; k++) chk("t3_spacing", rcyc[k] - rcyc[k-1], 6);

    // watchdog: busy stuck high from a dead cycle
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (m_dead) hit = 1;
    end
    chk("t4_reach_dead", hit, 1);
    pifBusy = 1'b1;
    nto = 0; ndone = 0; tgrant = -1; tto = -1; regrant = 0;
    prevg = grant;
    for (int i = 0; i < 40 && !regrant; i++) begin
      step();
      if (grant != '0 && prevg == '0) begin
        if (tgrant < 0) tgrant = i;
        else regrant = 1;
      end
      if (timeout) begin
        nto++;
        tto = i;
      end
      if (done != '0) ndone++;
      prevg = grant;
    end
    chk("t4_to_delay", tto - tgrant, 13);
    chk("t4_to_cnt", nto, 1);
    chk("t4_no_done", ndone, 0);
    chk("t4_regrant", regrant, 1);
    pifBusy = 1'b0;

    // asynchronous reset during CMD_WAIT1
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (m_active && m_t == m_off + 1) hit = 1;
    end
    chk("t5_reach_w1", hit, 1);
    chk("t5_cmd_live", pifCtrl[1:0], 2'b01);
    reset = 1'b1;
    #1;
    chk("t5_ctrl_async", pifCtrl, 4'b1100);
    chk("t5_grant_async", grant, 4'b0000);
    chk("t5_done_async", done, 4'b0000);
    step();
    reset = 1'b0;

    // enable dropped during WAIT_COMPLETE with requests pending
    reqCmd = 8'b11_01_10_01;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (m_active && m_t == m_off + 2) hit = 1;
    end
    chk("t6_reach", hit, 1);
    pifBusy = 1'b1;
    step();
    step();
    enable = 1'b0;
    step();
    pifBusy = 1'b0;
    ndone = 0; ngrant = 0;
    prevg = grant;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done != '0) ndone++;
      if (grant != '0 && prevg == '0) ngrant++;
      prevg = grant;
    end
    chk("t6_done", ndone, 1);
    chk("t6_no_grant", ngrant, 0);
    enable = 1'b1;
    hit = 0;
    for (int i = 0; i < 4 && !hit; i++) begin
      step();
      if (grant != '0) hit = 1;
    end
    chk("t6_regrant", hit, 1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++)
        reqCmd[2*r +: 2] = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      enable = ($urandom_range(0, 7) != 0);
      if ((i % 50) < 25) pifBusy = ($urandom_range(0, 3) == 0);
      else               pifBusy = ($urandom_range(0, 7) != 0);
      reset = ((i % 97) == 96);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wca_port_scheduler.md
# wca_port_scheduler

Round-robin scheduler that shares one port interface (pifCtrl/busy handshake) among `COUNT_PORTS` independent requesters. It latches one requester's 2-bit port command and drives the shared address. It waits for the address to settle, then issues the command and waits for the interface to go idle. Completion or timeout is reported back to that requester. It sits between the per-channel command sources and the port interface, and replaces a fixed sequential address sweep with demand-driven arbitration.

## Interface
- `COUNT_PORTS`, 4: number of requesters; 2..2^NBITS_ADDR.
- `NBITS_ADDR`, 2: port address width.
- `SETTLE_CYCLES`, 3: address settle cycles; 1..15.
- `TIMEOUT`, 255: maximum WAIT_COMPLETE cycles; 1..255; 0 disables the watchdog.

- `clock`, in, 1: port clock.
- `reset`, in, 1: asynchronous, active-high.
- `enable`, in, 1: permits new grants; does not abort an in-flight command.
- `reqCmd`, in, 2*COUNT_PORTS: requester i command at bits [2i+1:2i]; 2'b00 = PIFCMD_IDLE (no request).
- `pifBusy`, in, 1: interface busy status.
- `pifCtrl`, out, NBITS_ADDR+2: {addr, cmd}.
- `grant`, out, COUNT_PORTS: one-hot owner of the interface.
- `done`, out, COUNT_PORTS: one-cycle completion pulse to the owner.
- `timeout`, out, 1: one-cycle pulse when the watchdog expires.

## Operation
- States: IDLE, SETTLE, CMD, CMD_WAIT1, CMD_WAIT2, WAIT_COMPLETE.
- All outputs are registered.
- Reset values: state IDLE, addr = COUNT_PORTS-1, cmd = 2'b00, grant = 0, done = 0, timeout = 0, last winner = COUNT_PORTS-1.

**IDLE**
- Drives cmd = 00.
- If `enable` and any requester is nonzero, the winner is the first nonzero requester searching last+1, last+2, … modulo COUNT_PORTS.
- On winning: latch reqCmd[winner], set grant[winner], set addr = winner, set last = winner.
- If winner ≠ current addr, go to SETTLE with the counter loaded to SETTLE_CYCLES. Otherwise skip settling and go directly to CMD.

**SETTLE**
- Decrements the counter each cycle.
- Goes to CMD on the edge where the counter equals 1, giving exactly SETTLE_CYCLES cycles.

**CMD, CMD_WAIT1, CMD_WAIT2**
- cmd = latched command during these three cycles.
- Each state advances unconditionally.

**WAIT_COMPLETE**
- Drives cmd = 00.
- On each edge, if pifBusy = 0: pulse done[winner], clear grant, go to IDLE.
- Else increment the watchdog. When it reaches TIMEOUT: pulse timeout (done is not asserted), clear grant, go to IDLE.

**General rules**
- The watchdog clears on entry to CMD.
- reqCmd changes during a grant are ignored because the command is latched.
- A requester holding its request after done competes normally; it is last, so it has lowest priority.
- `enable` deassertion is honoured only in IDLE.
- Asynchronous reset at any state forces the reset values immediately. cmd drops to 00 mid-command, and no done is emitted.

## Timing
- Request present at IDLE edge E0: grant and addr are valid after E0.
- Address changes: cmd is nonzero after edges E0+S+1 through E0+S+3 (S = SETTLE_CYCLES). pifBusy is first sampled at edge E0+S+4.
- Same address: cmd is nonzero after E0+1 through E0+3. pifBusy is first sampled at E0+4.
- done is asserted for the single cycle following the completion edge. The next arbitration occurs at the following edge, one IDLE cycle later.
- Minimum transaction is 5 cycles (same address, busy never set). With address change it is 5+S.
- Timeout fires after TIMEOUT WAIT_COMPLETE edges with pifBusy = 1 throughout.

## Test plan
- **Single request, address change:** reset, then reqCmd[2] = 01, S = 3, pifBusy high for 6 cycles starting at the CMD_WAIT1 edge. Required: grant = 0100; addr = 2; cmd = 01 for exactly 3 cycles starting 4 cycles after grant; done = 0100 pulsed once; grant clears.
- **Round robin:** all four requesters assert 10, busy never set. Required: grant order 0001, 0010, 0100, 1000, 0001, with 9 cycles per transaction (8 plus the IDLE cycle).
- **Same-address back-to-back:** requester 3 only, requesting continuously. Required: SETTLE is skipped; addr stays 3; cmd pulses are spaced 6 cycles apart.
- **Watchdog:** TIMEOUT = 10, pifBusy stuck at 1. Required: timeout pulses once, 10 cycles after entering WAIT_COMPLETE; done stays 0; the scheduler returns to IDLE and re-grants.
- **Reset mid-command:** assert reset asynchronously during CMD_WAIT1. Required: cmd = 00, grant = 0, addr = COUNT_PORTS-1 immediately, without waiting for a clock edge; no done pulse.
- **Enable gating:** deassert enable during WAIT_COMPLETE with requests pending. Required: the current command completes with done; no new grant is made until enable returns high.
